// File: rtl/id_stage.sv
// Instruction decode stage: issues ALU/MEM ops to execute, resolves NOP/SEARCH/LOOP/HLT
// locally and steers fetch through Branch/Halt.
module id_stage (
  input  logic       CLK,
  input  logic       Init_n,
  input  logic [7:0] PC,
  input  logic [7:0] Instr,
  input  logic       Flag,
  input  logic       ex_ready,
  output logic       ex_valid,
  output logic [2:0] ex_op,
  output logic [4:0] ex_arg,
  output logic [7:0] ex_pc,
  output logic [1:0] Branch,
  output logic       Halt,
  output logic       Done,
  output logic       Err
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ARG_W = 5;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_ALU  = 3'd1;
  localparam logic [OP_W-1:0] OP_LOOP = 3'd2;
  localparam logic [OP_W-1:0] OP_SRCH = 3'd3;
  localparam logic [OP_W-1:0] OP_MEM  = 3'd4;
  localparam logic [OP_W-1:0] OP_IL5  = 3'd5;
  localparam logic [OP_W-1:0] OP_IL6  = 3'd6;
  localparam logic [OP_W-1:0] OP_HLT  = 3'd7;

  localparam logic [1:0] BR_NEXT = 2'd0;
  localparam logic [1:0] BR_BACK = 2'd1;
  localparam logic [1:0] BR_SKIP = 2'd2;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t           r_state;
  logic [ARG_W-1:0] r_cnt;
  logic             r_loop_active;

  logic             w_stall;
  logic             w_decode;
  logic [OP_W-1:0]  w_opcode;
  logic [ARG_W-1:0] w_k;
  logic             w_issue;
  logic             w_illegal;
  logic             w_hlt;
  logic             w_is_loop;

  // Decode and fetch steering; nothing is decoded in reset, while stalled or once halting.
  always_comb begin
    w_stall   = ex_valid & ~ex_ready;
    w_opcode  = Instr[7:5];
    w_k       = Instr[4:0];
    w_decode  = Init_n & (r_state == S_RUN) & ~w_stall;
    Branch    = BR_NEXT;
    Halt      = 1'b0;
    w_issue   = 1'b0;
    w_illegal = 1'b0;
    w_hlt     = 1'b0;
    w_is_loop = 1'b0;
    if (Init_n) begin
      if (!w_decode) begin
        Halt = 1'b1;
      end else begin
        case (w_opcode)
          OP_ALU, OP_MEM: w_issue = 1'b1;
          OP_SRCH:        Branch = Flag ? BR_SKIP : BR_NEXT;
          OP_LOOP: begin
            w_is_loop = 1'b1;
            if (r_loop_active ? (r_cnt != '0) : (w_k != '0)) Branch = BR_BACK;
          end
          OP_HLT: begin
            Halt  = 1'b1;
            w_hlt = 1'b1;
          end
          OP_IL5, OP_IL6: w_illegal = 1'b1;
          OP_NOP:         ;
          default:        ;
        endcase
      end
    end
  end

  // State, loop counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      r_state       <= S_RUN;
      r_cnt         <= '0;
      r_loop_active <= 1'b0;
      ex_valid      <= 1'b0;
      ex_op         <= '0;
      ex_arg        <= '0;
      ex_pc         <= '0;
      Done          <= 1'b0;
      Err           <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_decode) begin
            ex_valid <= w_issue;
            if (w_issue) begin
              ex_op  <= w_opcode;
              ex_arg <= w_k;
              ex_pc  <= PC;
            end
            if (w_illegal) Err <= 1'b1;
            if (w_is_loop) begin
              if (!r_loop_active) begin
                if (w_k != '0) begin
                  r_cnt         <= w_k - ARG_W'(1);
                  r_loop_active <= 1'b1;
                end
              end else if (r_cnt == '0) begin
                r_loop_active <= 1'b0;
              end else begin
                r_cnt <= r_cnt - ARG_W'(1);
              end
            end
            if (w_hlt) begin
              if (w_stall) begin
                r_state <= S_DRAIN;
              end else begin
                r_state <= S_HALTED;
                Done    <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
            r_state  <= S_HALTED;
            Done     <= 1'b1;
          end
        end
        S_HALTED: begin
          ex_valid <= 1'b0;
          Done     <= 1'b1;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic against an
// instruction-level reference model.
module tb_id_stage;

  logic       CLK = 1'b0;
  logic       Init_n = 1'b0;
  logic [7:0] PC = 8'd0;
  logic [7:0] Instr = 8'd0;
  logic       Flag = 1'b0;
  logic       ex_ready = 1'b0;
  logic       ex_valid;
  logic [2:0] ex_op;
  logic [4:0] ex_arg;
  logic [7:0] ex_pc;
  logic [1:0] Branch;
  logic       Halt;
  logic       Done;
  logic       Err;

  id_stage dut (
    .CLK(CLK), .Init_n(Init_n), .PC(PC), .Instr(Instr), .Flag(Flag),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op(ex_op), .ex_arg(ex_arg),
    .ex_pc(ex_pc), .Branch(Branch), .Halt(Halt), .Done(Done), .Err(Err)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the op presented to execute, program status, loop bookkeeping.
  bit       m_busy;
  int       m_op, m_arg, m_pc;
  bit       m_done, m_err, m_halted;
  bit       m_looping;
  int       m_left;

  logic [1:0] obs_branch;
  logic       obs_halt;
  logic [7:0] rom [256];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic rdy, input logic flg,
                      input logic [7:0] pc, input logic [7:0] ins);
    int  op, k;
    int  e_br;
    bit  e_halt, consume;
    @(negedge CLK);
    Init_n = rst_n; ex_ready = rdy; Flag = flg; PC = pc; Instr = ins;
    #1;
    op = int'(ins[7:5]); k = int'(ins[4:0]);
    e_br = 0; e_halt = 0; consume = 0;
    if (rst_n) begin
      if (m_halted || (m_busy && !rdy)) begin
        e_halt = 1;
      end else begin
        consume = 1;
        if (op == 2) e_br = (m_looping ? (m_left > 0) : (k > 0)) ? 1 : 0;
        if (op == 3) e_br = flg ? 2 : 0;
        if (op == 7) e_halt = 1;
      end
    end
    chk("branch", 8'(Branch), 8'(e_br));
    chk("halt", 8'(Halt), 8'(e_halt));
    obs_branch = Branch;
    obs_halt   = Halt;
    @(posedge CLK);
    if (!rst_n) begin
      m_busy = 0; m_op = 0; m_arg = 0; m_pc = 0;
      m_done = 0; m_err = 0; m_halted = 0; m_looping = 0; m_left = 0;
    end else if (consume) begin
      m_busy = (op == 1) || (op == 4);
      if (m_busy) begin m_op = op; m_arg = k; m_pc = int'(pc); end
      if (op == 5 || op == 6) m_err = 1;
      if (op == 2) begin
        if (!m_looping) begin
          if (k > 0) begin m_looping = 1; m_left = k - 1; end
        end else if (m_left == 0) begin
          m_looping = 0;
        end else begin
          m_left--;
        end
      end
      if (op == 7) begin m_halted = 1; m_done = 1; end
    end
    #1;
    chk("ex_valid", 8'(ex_valid), 8'(m_busy));
    chk("ex_op", 8'(ex_op), 8'(m_op));
    chk("ex_arg", 8'(ex_arg), 8'(m_arg));
    chk("ex_pc", ex_pc, 8'(m_pc));
    chk("done", 8'(Done), 8'(m_done));
    chk("err", 8'(Err), 8'(m_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int n_back, n_alu;
    int op;
    logic [7:0] ins;

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[4] = 8'h21;
    rom[5] = 8'h43;

    // Reset values
    step(0, 0, 0, 8'h00, 8'h00);
    chk("rst_valid", 8'(ex_valid), 8'd0);
    chk("rst_done", 8'(Done), 8'd0);

    // ALU 0x25 at PC 3
    step(1, 1, 0, 8'd3, 8'h25);
    chk("alu_valid", 8'(ex_valid), 8'd1);
    chk("alu_op", 8'(ex_op), 8'd1);
    chk("alu_arg", 8'(ex_arg), 8'd5);
    chk("alu_pc", ex_pc, 8'd3);

    // MEM stalled three cycles, then retire and back-to-back ALU
    step(1, 1, 0, 8'd4, 8'h87);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'd5, 8'h2A);
      chk("stall_halt", 8'(obs_halt), 8'd1);
      chk("stall_op", 8'(ex_op), 8'd4);
    end
    step(1, 1, 0, 8'd5, 8'h2A);
    chk("b2b_op", 8'(ex_op), 8'd1);
    step(1, 1, 0, 8'd6, 8'h00);

    // SEARCH both ways
    step(1, 1, 1, 8'd7, 8'h60);
    chk("search_hit", 8'(obs_branch), 8'd2);
    step(1, 1, 0, 8'd8, 8'h60);
    chk("search_miss", 8'(obs_branch), 8'd0);

    // ALU + LOOP 3 driven through a fetch model
    pc = 4; n_back = 0; n_alu = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 8'(pc), rom[pc]);
      if (obs_branch == 2'd1) n_back++;
      if (ex_valid && ex_op == 3'd1) n_alu++;
      if (!obs_halt) pc = (pc + (obs_branch == 2'd1 ? -1 : (obs_branch == 2'd2 ? 2 : 1))) & 8'hFF;
    end
    chk("loop_backs", 8'(n_back), 8'd3);
    chk("loop_alu_issues", 8'(n_alu), 8'd4);
    chk("loop_exit_pc", 8'(pc), 8'd8);

    // HLT behind a stalled MEM
    step(1, 1, 0, 8'd10, 8'h91);
    step(1, 0, 0, 8'd11, 8'hE0);
    chk("drain_halt", 8'(obs_halt), 8'd1);
    chk("drain_done", 8'(Done), 8'd0);
    step(1, 1, 0, 8'd11, 8'hE0);
    chk("halted_done", 8'(Done), 8'd1);
    chk("halted_valid", 8'(ex_valid), 8'd0);
    step(1, 1, 0, 8'd12, 8'h21);
    chk("halted_noissue", 8'(ex_valid), 8'd0);

    // Illegal opcode, then reset mid-loop
    step(0, 0, 0, 8'd0, 8'h00);
    step(1, 1, 0, 8'd0, 8'hA0);
    chk("illegal_err", 8'(Err), 8'd1);
    chk("illegal_noissue", 8'(ex_valid), 8'd0);
    step(1, 1, 0, 8'd1, 8'h21);
    step(1, 1, 0, 8'd2, 8'h43);
    step(1, 1, 0, 8'd1, 8'h21);
    step(0, 1, 0, 8'd2, 8'h43);
    chk("rst_err", 8'(Err), 8'd0);
    chk("rst_valid2", 8'(ex_valid), 8'd0);
    chk("rst_pc", ex_pc, 8'd0);
    step(1, 1, 0, 8'd2, 8'h41);
    chk("loop_fresh", 8'(obs_branch), 8'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 7));
      if (op == 7 && $urandom_range(0, 7) != 0) op = 0;
      if (op == 2 && $urandom_range(0, 1) == 0) ins = {3'd2, 5'($urandom_range(0, 3))};
      else ins = {3'(op), 5'($urandom)};
      step(($urandom_range(0, 39) != 0) && !(m_halted && $urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom), 8'($urandom), ins);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter none; the instruction word is fixed at 8 bits: opcode Instr[7:5], argument Instr[4:0].
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 Init_n  input  1  reset, synchronous, active-low (sampled only at posedge CLK).
REQ-004 PC  input  8  current fetch address from the fetch stage.
REQ-005 Instr  input  8  instruction at PC, valid in the same cycle (asynchronous instruction ROM).
REQ-006 Flag  input  1  search-match condition from execute, stable whenever no op is outstanding.
REQ-007 ex_ready  input  1  execute accepts the presented op at this posedge.
REQ-008 ex_valid  output  1  registered; an op is presented to execute.
REQ-009 ex_op  output  3  registered opcode; ex_arg  output  5  registered argument; ex_pc  output  8  registered PC of the op.
REQ-010 Branch  output  2  combinational to fetch: 0 = PC+1, 1 = PC-1, 2 = PC+2; 3 never driven.
REQ-011 Halt  output  1  combinational to fetch: hold PC.
REQ-012 Done  output  1  registered; program finished. Err  output  1  registered, sticky illegal-opcode flag.

Function
REQ-013 Opcodes: 000 NOP, 001 ALU, 010 LOOP, 011 SEARCH, 100 MEM, 101/110 illegal, 111 HLT.
REQ-014 stall = ex_valid & ~ex_ready; while stall: Halt=1, Branch=0, no decode, loop state and FSM unchanged, ex_* held.
REQ-015 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-016 RUN, no stall: the instruction on Instr is consumed this cycle; Halt=0 unless stated below.
REQ-017 ALU/MEM consumed: at posedge ex_valid<=1, ex_op<=opcode, ex_arg<=Instr[4:0], ex_pc<=PC; Branch=0.
REQ-018 Presented op retires at the posedge where ex_valid=1 and ex_ready=1; ex_valid drops then unless a new ALU/MEM is consumed in that same cycle (back-to-back: ex_valid stays 1, fields reload).
REQ-019 NOP consumed: Branch=0, no issue; if ex_ready=1 that cycle, ex_valid<=0.
REQ-020 SEARCH consumed: Branch=2 if Flag=1 else 0; no issue.
REQ-021 LOOP k, loop_active=0: k=0 -> Branch=0; k>0 -> Branch=1, cnt<=k-1, loop_active<=1.
REQ-022 LOOP, loop_active=1: cnt=0 -> Branch=0, loop_active<=0; cnt>0 -> Branch=1, cnt<=cnt-1 (instruction before LOOP executes k+1 times total; nesting unsupported).
REQ-023 cnt is 5 bits, never wraps; decrements only on REQ-022 path.
REQ-024 Illegal opcode consumed: behaves as NOP, Err<=1 (held until reset).
REQ-025 HLT consumed: Halt=1, Branch=0; next state DRAIN if ex_valid & ~ex_ready, else HALTED.
REQ-026 DRAIN: Halt=1, Branch=0, no decode; goes HALTED at posedge where ex_valid retires (ex_valid<=0).
REQ-027 HALTED: Halt=1, Branch=0, ex_valid=0, Done=1 from entry posedge onward; exit only by reset.

Reset
REQ-028 Init_n=0 at posedge: state RUN, ex_valid=0, ex_op=0, ex_arg=0, ex_pc=0, cnt=0, loop_active=0, Done=0, Err=0.
REQ-029 While Init_n=0: Halt=0, Branch=0; reset mid-stall or mid-loop discards outstanding op and loop state without retiring it.
REQ-030 First instruction after Init_n rises is decoded in that same cycle.

Verification
REQ-031 ALU 0x25 at PC 3, ex_ready=1 -> next cycle ex_valid=1, ex_op=1, ex_arg=5, ex_pc=3, Halt=0, Branch=0.
REQ-032 MEM issued, ex_ready=0 for 3 cycles -> Halt=1, Branch=0, ex_* held 3 cycles; ex_ready=1 -> retire, next instr decoded.
REQ-033 PC 4 = ALU, PC 5 = LOOP 3 -> Branch=1 three times, ALU issued 4 times, then Branch=0, loop_active=0.
REQ-034 SEARCH with Flag=1 -> Branch=2; with Flag=0 -> Branch=0.
REQ-035 HLT while MEM outstanding, ex_ready=0 -> DRAIN, Halt=1, Done=0; ex_ready=1 -> HALTED, Done=1, ex_valid=0.
REQ-036 Opcode 101 -> Err=1, no issue; Init_n=0 mid-LOOP with cnt=2 -> all outputs to reset values, Err=0.
